// File: rtl/pb_io_bank.sv
// pb_io_bank: parametrised KCPSM6 I/O register bank with readback and a latched, maskable interrupt
module pb_io_bank #(
    parameter int          NUM_IN      = 16,
    parameter int          NUM_OUT     = 16,
    parameter logic [7:0]  IN_BASE     = 8'h00,
    parameter logic [7:0]  OUT_BASE    = 8'h00,
    parameter logic [7:0]  INTCTL_ADDR = 8'hFF,
    parameter bit          READBACK    = 1'b1,
    parameter bit          INT_EDGE    = 1'b1,
    parameter logic [7:0]  OUT_RST_VAL = 8'h00
) (
    input  logic                   sysclk,
    input  logic                   sysreset,
    input  logic [7:0]             port_id,
    input  logic                   write_strobe,
    input  logic                   read_strobe,
    input  logic [7:0]             io_data_in,
    output logic [7:0]             io_data_out,
    input  logic [8*NUM_IN-1:0]    in_bus,
    output logic [8*NUM_OUT-1:0]   out_bus,
    output logic [NUM_OUT-1:0]     out_wr,
    input  logic                   interrupt_request,
    input  logic                   interrupt_ack,
    output logic                   interrupt
);
    typedef enum logic {IDLE, ASSERTED} state_t;
    localparam logic [8:0] IN_END  = {1'b0, IN_BASE} + 9'(NUM_IN);
    localparam logic [8:0] OUT_END = {1'b0, OUT_BASE} + 9'(NUM_OUT);
    logic [NUM_OUT-1:0][7:0] out_q, out_d;
    logic [NUM_OUT-1:0]      out_wr_q, out_wr_d;
    logic [7:0]              rdata_q, rdata_d, in_val, rb_val, in_off, out_off;
    logic                    en_q, en_d, pend_q, pend_d, req_q;
    logic                    in_hit, out_hit, ctl_hit, ctl_wr, evt, ack;
    state_t                  state_q, state_d;
    logic                    unused_read_strobe;
    assign unused_read_strobe = read_strobe;
    always_comb begin
        in_hit  = {1'b0, port_id} >= {1'b0, IN_BASE} && {1'b0, port_id} < IN_END;
        out_hit = {1'b0, port_id} >= {1'b0, OUT_BASE} && {1'b0, port_id} < OUT_END;
        ctl_hit = port_id == INTCTL_ADDR;
        ctl_wr  = write_strobe && ctl_hit;
        in_off  = port_id - IN_BASE;
        out_off = port_id - OUT_BASE;
        out_d    = out_q;
        out_wr_d = '0;
        in_val   = 8'h00;
        rb_val   = 8'h00;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (write_strobe && out_hit && !ctl_hit && out_off == 8'(i)) begin
                out_d[i]    = io_data_in;
                out_wr_d[i] = 1'b1;
            end
            if (out_off == 8'(i)) rb_val = out_q[i];
        end
        for (int j = 0; j < NUM_IN; j++)
            if (in_off == 8'(j)) in_val = in_bus[8*j +: 8];
        rdata_d = ctl_hit ? {6'b0, pend_q, en_q} :
                  in_hit ? in_val :
                  (out_hit && READBACK) ? rb_val : 8'h00;
        // A fresh event always wins over ack or write-1-to-clear so none is lost
        evt     = INT_EDGE ? interrupt_request & ~req_q : interrupt_request;
        ack     = interrupt_ack && state_q == ASSERTED;
        en_d    = ctl_wr ? io_data_in[0] : en_q;
        pend_d  = evt | (pend_q & ~ack & ~(ctl_wr & io_data_in[1]));
        state_d = state_q == IDLE ? ((pend_q && en_q) ? ASSERTED : IDLE) :
                  ((ack || !en_d) ? IDLE : ASSERTED);
    end
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            out_q    <= {NUM_OUT{OUT_RST_VAL}};
            out_wr_q <= '0;
            rdata_q  <= 8'h00;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
            req_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            out_q    <= out_d;
            out_wr_q <= out_wr_d;
            rdata_q  <= rdata_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            req_q    <= interrupt_request;
            state_q  <= state_d;
        end
    end
    assign out_bus     = out_q;
    assign out_wr      = out_wr_q;
    assign io_data_out = rdata_q;
    assign interrupt   = state_q == ASSERTED;
endmodule
